scp_079_ctrl: RTL and testbench
===============================

# scp_079_ctrl

Parametrised successor to the `scp_079` containment alert controller. It decodes the green/yellow/red threat-level inputs into a five-state alert FSM and drives alarms `a1`/`a2`/`a3` and `cheat_out`. Unlike `scp_079`, it owns its dwell timer internally, takes all dwell times as parameters, adds an operator `clear` for lockdown exit, and detects illegal colour encodings. It sits between the sensor-colour front end and the alarm drivers.

## Interface
- `TIMER_W`, 6, width of the internal dwell timer; all `T_*` must be in 1..2^TIMER_W-1.
- `T_IDLE`, 35, cycles in GREEN before the periodic self-check.
- `T_HOLD`, 5, cycles spent in HOLD (self-check).
- `T_RED`, 25, cycles of sustained yellow or red before escalation.
- `T_LOCK`, 12, minimum cycles in LOCK.
- `CHEAT_LEN`, 3, consecutive illegal-colour cycles that trigger `cheat_out`; range 1..15.

Ports:
- `clock` in 1: rising-edge system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `green` in 1: threat level green.
- `yellow` in 1: threat level yellow.
- `red` in 1: threat level red.
- `clear` in 1: operator acknowledge, level-sampled.
- `state` out 3: encoding GREEN=0, RED=1, HOLD=2, YELLOW=3, LOCK=4.
- `timer` out TIMER_W: cycles since entry to the current state, saturating.
- `a1` out 1: high in YELLOW.
- `a2` out 1: high in RED.
- `a3` out 1: high in LOCK.
- `cheat_out` out 1: sticky illegal-input flag.

## Operation
- Colour decode:
  - Legal when exactly one of green/yellow/red is high.
  - Illegal when none or more than one is high.
  - Illegal cycles cause no colour-driven transition.
- Dwell timer:
  - Cleared to 0 on every state change.
  - Otherwise increments each cycle, saturating at all-ones.
  - "Timeout T" means `timer == T-1` on the sampling edge.
- Transitions are evaluated on each rising edge, highest priority first:
  1. Cheat trigger.
  2. Colour-driven transition.
  3. Timeout.
- GREEN:
  - red → RED.
  - yellow → YELLOW.
  - green with timeout T_IDLE → HOLD.
- HOLD:
  - red → RED.
  - yellow → YELLOW.
  - timeout T_HOLD → GREEN. Green does not extend HOLD.
- YELLOW:
  - red → RED.
  - green → GREEN.
  - yellow with timeout T_RED → RED.
- RED:
  - green → GREEN.
  - yellow keeps RED; the timer continues.
  - red with timeout T_RED → LOCK.
- LOCK:
  - Colour inputs are ignored.
  - Exit to GREEN when `timer >= T_LOCK-1` and `clear`=1 and `red`=0; otherwise stay.
- Illegal-colour counter:
  - 4-bit counter of consecutive illegal cycles, cleared on any legal cycle.
  - When it reaches CHEAT_LEN, `cheat_out` sets on that edge.
  - If the FSM is not already in LOCK, it enters LOCK on the same edge with the timer cleared.
  - The counter saturates at CHEAT_LEN.
- `cheat_out`:
  - Cleared only by reset or by the LOCK→GREEN exit edge.
  - `clear` outside LOCK has no effect.
- `a1`/`a2`/`a3` are pure Moore decodes of the `state` register, with no extra latency.

## Timing
- All outputs are registered and change only on a rising `clock` edge, except on reset.
- Reset asserted at any time, mid-state included: immediately `state`=0, `timer`=0, `a1`=`a2`=`a3`=0, `cheat_out`=0, illegal counter=0.
- First edge after `reset_n` rises: normal GREEN operation with timer 0→1.
- Each state persists exactly T cycles on its timeout path: GREEN T_IDLE, HOLD T_HOLD, YELLOW/RED T_RED.
- Colour-driven transitions take effect on the first edge that samples the new colour (1-cycle input-to-state latency).
- A legal colour change and a timeout on the same edge: the colour wins (e.g. red arriving at GREEN timeout → RED, not HOLD).
- Cheat trigger coincident with any other condition: cheat wins.
- With T_LOCK=1, LOCK exit is possible on the first edge after entry.
- The timer saturates in LOCK when `clear` is withheld; it never wraps.

## Test plan
- Reset, green held 35 cycles, then 5 more → `state`=0 for exactly 35 cycles, then 2 for 5 cycles, then back to 0; `timer` reaches 34 and then 4 before clearing.
- From GREEN, red held 25 cycles, then 12 more, then `clear`=1 with red=0 → RED (`a2`=1) for 25 cycles, LOCK (`a3`=1) for at least 12, then GREEN on the clear edge.
- Yellow held 25 cycles → YELLOW (`a1`=1) for 25, then RED; green pulse at YELLOW timer 10 → GREEN instead.
- green+red together for 3 cycles from GREEN → `cheat_out`=1 and `state`=4 on the 3rd edge; 2 illegal cycles followed by a legal one → no trigger.
- LOCK with `clear` withheld for 80 cycles → `timer` saturates at 63 and `state` stays 4; `clear` with red=1 → no exit.
- `reset_n` pulsed low mid-RED at timer 10 → all outputs 0 immediately, without a clock edge; after release, GREEN timing restarts from 0.

Source files
------------

// File: rtl/scp_079_ctrl.sv
// Containment alert controller: colour-driven five-state FSM with internal dwell timer and illegal-colour lockout.
// All outputs registered (alarms decode the state register); 1-cycle input-to-state latency, no backpressure.
module scp_079_ctrl #(
  parameter int TIMER_W   = 6,
  parameter int T_IDLE    = 35,
  parameter int T_HOLD    = 5,
  parameter int T_RED     = 25,
  parameter int T_LOCK    = 12,
  parameter int CHEAT_LEN = 3
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               green,
  input  logic               yellow,
  input  logic               red,
  input  logic               clear,
  output logic [2:0]         state,
  output logic [TIMER_W-1:0] timer,
  output logic               a1,
  output logic               a2,
  output logic               a3,
  output logic               cheat_out
);

  typedef enum logic [2:0] {
    S_GREEN  = 3'd0,
    S_RED    = 3'd1,
    S_HOLD   = 3'd2,
    S_YELLOW = 3'd3,
    S_LOCK   = 3'd4
  } state_t;

  localparam logic [TIMER_W-1:0] IDLE_LAST = TIMER_W'(T_IDLE - 1);
  localparam logic [TIMER_W-1:0] HOLD_LAST = TIMER_W'(T_HOLD - 1);
  localparam logic [TIMER_W-1:0] RED_LAST  = TIMER_W'(T_RED - 1);
  localparam logic [TIMER_W-1:0] LOCK_LAST = TIMER_W'(T_LOCK - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX = '1;
  localparam logic [3:0]         CHEAT_N   = 4'(CHEAT_LEN);
  localparam logic [3:0]         CHEAT_M1  = 4'(CHEAT_LEN - 1);

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [3:0]         ill_cnt_q, ill_cnt_d;
  logic               cheat_q, cheat_d;

  logic legal, col_g, col_y, col_r, cheat_trig, lock_exit;

  always_comb begin
    legal = ({green, yellow, red} == 3'b100) ||
            ({green, yellow, red} == 3'b010) ||
            ({green, yellow, red} == 3'b001);
    col_g = legal & green;
    col_y = legal & yellow;
    col_r = legal & red;
    // Trigger on the edge the run length reaches CHEAT_LEN, and keep asserting while it persists.
    cheat_trig = !legal && (ill_cnt_q >= CHEAT_M1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_GREEN;
      timer_q   <= '0;
      ill_cnt_q <= '0;
      cheat_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      ill_cnt_q <= ill_cnt_d;
      cheat_q   <= cheat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (cheat_trig) begin
      state_d = S_LOCK;
    end else begin
      unique case (state_q)
        S_GREEN: begin
          if (col_r)                           state_d = S_RED;
          else if (col_y)                      state_d = S_YELLOW;
          else if (col_g && timer_q == IDLE_LAST) state_d = S_HOLD;
        end
        S_HOLD: begin
          if (col_r)                           state_d = S_RED;
          else if (col_y)                      state_d = S_YELLOW;
          else if (timer_q == HOLD_LAST)       state_d = S_GREEN;
        end
        S_YELLOW: begin
          if (col_r)                           state_d = S_RED;
          else if (col_g)                      state_d = S_GREEN;
          else if (col_y && timer_q == RED_LAST) state_d = S_RED;
        end
        S_RED: begin
          if (col_g)                           state_d = S_GREEN;
          else if (col_r && timer_q == RED_LAST) state_d = S_LOCK;
        end
        S_LOCK: begin
          if (timer_q >= LOCK_LAST && clear && !red) state_d = S_GREEN;
        end
        default: state_d = S_GREEN;
      endcase
    end
  end

  always_comb begin
    lock_exit = (state_q == S_LOCK) && (state_d == S_GREEN);
    if (state_d != state_q)       timer_d = '0;
    else if (timer_q == TIMER_MAX) timer_d = timer_q;
    else                          timer_d = timer_q + TIMER_W'(1);
    if (legal)           ill_cnt_d = '0;
    else if (cheat_trig) ill_cnt_d = CHEAT_N;
    else                 ill_cnt_d = ill_cnt_q + 4'd1;
    if (cheat_trig)     cheat_d = 1'b1;
    else if (lock_exit) cheat_d = 1'b0;
    else                cheat_d = cheat_q;
  end

  always_comb begin
    a1 = 1'b0;
    a2 = 1'b0;
    a3 = 1'b0;
    unique case (state_q)
      S_YELLOW: a1 = 1'b1;
      S_RED:    a2 = 1'b1;
      S_LOCK:   a3 = 1'b1;
      default:  ;
    endcase
  end

  assign state     = state_q;
  assign timer     = timer_q;
  assign cheat_out = cheat_q;

endmodule

// File: tb/tb_scp_079_ctrl.sv
// Directed bench for scp_079_ctrl: vector table plus hand-written multi-cycle sequences.
module tb_scp_079_ctrl;

  localparam logic [2:0] GRN = 3'd0, RED = 3'd1, HLD = 3'd2, YEL = 3'd3, LCK = 3'd4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       green = 1'b0, yellow = 1'b0, red = 1'b0, clear = 1'b0;
  logic [2:0] state;
  logic [5:0] timer;
  logic       a1, a2, a3, cheat_out;

  int n_vec = 0;
  int n_err = 0;

  scp_079_ctrl dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .green     (green),
    .yellow    (yellow),
    .red       (red),
    .clear     (clear),
    .state     (state),
    .timer     (timer),
    .a1        (a1),
    .a2        (a2),
    .a3        (a3),
    .cheat_out (cheat_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       g, y, r, c;
    logic [2:0] st;
    int         tm;
    logic       ch;
  } vec_t;

  vec_t tbl[18];

  task automatic check(input string name, input logic [2:0] es, input int et, input logic ec);
    logic [5:0] act, exp_v;
    n_vec++;
    act   = {state, a1, a2, a3};
    exp_v = {es, es == YEL, es == RED, es == LCK};
    if (act !== exp_v || int'(timer) != et || cheat_out !== ec) begin
      n_err++;
      $display("FAIL %s: got state=%0d a1a2a3=%b%b%b timer=%0d cheat=%b, want state=%0d a1a2a3=%b%b%b timer=%0d cheat=%b",
               name, state, a1, a2, a3, timer, cheat_out,
               es, es == YEL, es == RED, es == LCK, et, ec);
    end
  endtask

  task automatic step(input logic g, input logic y, input logic r, input logic c);
    green = g; yellow = y; red = r; clear = c;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    green = 0; yellow = 0; red = 0; clear = 0;
    #1;
    check("reset_async", GRN, 0, 1'b0);
    @(negedge clock);
    @(negedge clock);
    check("reset_held", GRN, 0, 1'b0);
    reset_n = 1'b1;
  endtask

  initial begin
    //          g  y  r  c  state tmr cheat
    tbl[0]  = '{1, 0, 0, 0, GRN, 1, 0};
    tbl[1]  = '{1, 0, 0, 1, GRN, 2, 0};
    tbl[2]  = '{0, 1, 0, 0, YEL, 0, 0};
    tbl[3]  = '{0, 1, 0, 0, YEL, 1, 0};
    tbl[4]  = '{1, 0, 0, 0, GRN, 0, 0};
    tbl[5]  = '{0, 0, 1, 0, RED, 0, 0};
    tbl[6]  = '{0, 1, 0, 0, RED, 1, 0};
    tbl[7]  = '{0, 0, 1, 0, RED, 2, 0};
    tbl[8]  = '{1, 0, 0, 0, GRN, 0, 0};
    tbl[9]  = '{0, 0, 0, 0, GRN, 1, 0};
    tbl[10] = '{1, 0, 1, 0, GRN, 2, 0};
    tbl[11] = '{1, 0, 0, 0, GRN, 3, 0};
    tbl[12] = '{1, 0, 1, 0, GRN, 4, 0};
    tbl[13] = '{1, 1, 1, 0, GRN, 5, 0};
    tbl[14] = '{0, 0, 0, 0, LCK, 0, 1};
    tbl[15] = '{0, 0, 0, 0, LCK, 1, 1};
    tbl[16] = '{0, 0, 1, 1, LCK, 2, 1};
    tbl[17] = '{1, 0, 0, 1, LCK, 3, 1};

    do_reset();
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].g, tbl[i].y, tbl[i].r, tbl[i].c);
      check($sformatf("tbl[%0d]", i), tbl[i].st, tbl[i].tm, tbl[i].ch);
    end

    // GREEN idle timeout into HOLD and back
    do_reset();
    for (int i = 1; i <= 40; i++) begin
      step(1, 0, 0, 0);
      if (i < 35)      check($sformatf("idle[%0d]", i), GRN, i, 1'b0);
      else if (i < 40) check($sformatf("idle[%0d]", i), HLD, i - 35, 1'b0);
      else             check($sformatf("idle[%0d]", i), GRN, 0, 1'b0);
    end

    // red arriving on the GREEN timeout edge wins over HOLD
    do_reset();
    for (int i = 1; i <= 34; i++) step(1, 0, 0, 0);
    check("idle_pre", GRN, 34, 1'b0);
    step(0, 0, 1, 0);
    check("red_vs_timeout", RED, 0, 1'b0);

    // RED escalation to LOCK, then operator clear
    do_reset();
    for (int i = 1; i <= 37; i++) begin
      step(0, 0, 1, 0);
      if (i <= 25) check($sformatf("red[%0d]", i), RED, i - 1, 1'b0);
      else         check($sformatf("red[%0d]", i), LCK, i - 26, 1'b0);
    end
    step(1, 0, 0, 1);
    check("lock_clear_exit", GRN, 0, 1'b0);

    // YELLOW escalation, then green pulse at YELLOW timer 10
    do_reset();
    for (int i = 1; i <= 26; i++) begin
      step(0, 1, 0, 0);
      if (i <= 25) check($sformatf("yel[%0d]", i), YEL, i - 1, 1'b0);
      else         check("yel_escalate", RED, 0, 1'b0);
    end
    step(1, 0, 0, 0);
    check("red_to_green", GRN, 0, 1'b0);
    for (int i = 0; i <= 10; i++) step(0, 1, 0, 0);
    check("yel_t10", YEL, 10, 1'b0);
    step(1, 0, 0, 0);
    check("yel_green_pulse", GRN, 0, 1'b0);

    // cheat trigger, early clear, saturation, clear blocked by red, exit
    do_reset();
    step(1, 0, 1, 0);
    check("cheat_1", GRN, 1, 1'b0);
    step(1, 0, 1, 0);
    check("cheat_2", GRN, 2, 1'b0);
    step(1, 0, 1, 0);
    check("cheat_3", LCK, 0, 1'b1);
    step(1, 0, 0, 1);
    check("lock_early_clear", LCK, 1, 1'b1);
    for (int j = 1; j <= 80; j++) begin
      step(1, 0, 0, 0);
      if (j % 20 == 0 || j >= 62)
        check($sformatf("lock_sat[%0d]", j), LCK, (j + 1 > 63) ? 63 : j + 1, 1'b1);
    end
    step(0, 0, 1, 1);
    check("clear_with_red", LCK, 63, 1'b1);
    step(1, 0, 0, 1);
    check("cheat_exit", GRN, 0, 1'b0);

    // asynchronous reset mid-RED
    do_reset();
    for (int i = 0; i <= 10; i++) step(0, 0, 1, 0);
    check("red_t10", RED, 10, 1'b0);
    reset_n = 1'b0;
    #2;
    check("async_mid_red", GRN, 0, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    step(1, 0, 0, 0);
    check("post_reset_g1", GRN, 1, 1'b0);
    step(1, 0, 0, 0);
    check("post_reset_g2", GRN, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
